nibble_serial_exec: RTL and testbench

- Execute stage directly downstream of the instruction decoder; consumes one decoded ALU operation (two 32-bit operands, opcode, destination register) per transaction.
- Computes the result serially, one 4-bit nibble per clock from nibble 0 (LSB) to nibble 7, with ripple carry held in a flop between nibbles.
- Presents the 32-bit result plus destination register to the writeback stage over a valid/ready handshake.

---
 rtl/exec_pkg.sv | 21 ++
 rtl/nibble_serial_exec_slice.sv | 41 ++++
 rtl/nibble_serial_exec.sv | 137 +++++++++++++
 tb/tb_nibble_serial_exec.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the nibble-serial execute stage: opcodes, FSM states
// and the width of one serial slice.
package exec_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [2:0] {
    EXEC_ADD = 3'd0,
    EXEC_SUB = 3'd1,
    EXEC_AND = 3'd2,
    EXEC_OR  = 3'd3,
    EXEC_XOR = 3'd4
  } ExecOp;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ExecState;

endpackage

// File: rtl/nibble_serial_exec_slice.sv
// One 4-bit slice of the serial ALU. Subtraction is done as A + ~B + 1,
// so B is inverted here and the +1 arrives through carry_in on nibble 0.
// Opcodes outside the defined set fall through to the adder path.
module nibble_slice
  import exec_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_nib,
  input  logic [NIBBLE_W-1:0] b_nib,
  input  logic                carry_in,
  input  logic [2:0]          op,
  output logic [NIBBLE_W-1:0] res_nib,
  output logic                carry_out
);

  logic [NIBBLE_W-1:0] bEff;
  logic [NIBBLE_W:0]   sum;

  // Select the nibble result; logic ops never propagate a carry
  always_comb begin
    bEff      = (op == EXEC_SUB) ? ~b_nib : b_nib;
    sum       = {1'b0, a_nib} + {1'b0, bEff} + {{NIBBLE_W{1'b0}}, carry_in};
    res_nib   = sum[NIBBLE_W-1:0];
    carry_out = sum[NIBBLE_W];
    case (op)
      EXEC_AND: begin
        res_nib   = a_nib & b_nib;
        carry_out = 1'b0;
      end
      EXEC_OR: begin
        res_nib   = a_nib | b_nib;
        carry_out = 1'b0;
      end
      EXEC_XOR: begin
        res_nib   = a_nib ^ b_nib;
        carry_out = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nibble_serial_exec.sv
// Nibble-serial execute stage: accepts one decoded ALU op, walks the
// operands one nibble per clock (LSB first) with the carry held in a flop,
// then offers the result to writeback on a valid/ready handshake.
// Optional zero flag output is enabled by NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN.
module nibble_serial_exec
  import exec_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int RD_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic [RD_W-1:0]          in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_result,
  output logic [RD_W-1:0]          out_rd,
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
  output logic                     out_zero,
`endif
  output logic                     out_carry
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  ExecState            state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic [W-1:0]        opA_q;
  logic [W-1:0]        opB_q;
  logic [2:0]          op_q;
  logic [RD_W-1:0]     rd_q;
  logic [W-1:0]        result_q;
  logic                outValid_q;
  logic                outCarry_q;
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
  logic                nonZero_q;
  logic                outZero_q;
`endif

  logic [NIBBLE_W-1:0] aNib;
  logic [NIBBLE_W-1:0] bNib;
  logic [NIBBLE_W-1:0] resNib_d;
  logic                carry_d;

  assign aNib = opA_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign bNib = opB_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_slice u_slice (
    .a_nib     (aNib),
    .b_nib     (bNib),
    .carry_in  (carry_q),
    .op        (op_q),
    .res_nib   (resNib_d),
    .carry_out (carry_d)
  );

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = outValid_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_carry  = outCarry_q;
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
  assign out_zero   = outZero_q;
`endif

  // Control FSM, operand latches, nibble index and result accumulation
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      opA_q      <= '0;
      opB_q      <= '0;
      op_q       <= 3'd0;
      rd_q       <= '0;
      result_q   <= '0;
      outValid_q <= 1'b0;
      outCarry_q <= 1'b0;
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
      nonZero_q  <= 1'b0;
      outZero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q     <= in_a;
            opB_q     <= in_b;
            op_q      <= in_op;
            rd_q      <= in_rd;
            result_q  <= '0;
            idx_q     <= '0;
            carry_q   <= (in_op == EXEC_SUB);
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
            nonZero_q <= 1'b0;
`endif
            state_q   <= RUN;
          end
        end
        RUN: begin
          result_q[NIBBLE_W*idx_q +: NIBBLE_W] <= resNib_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
          nonZero_q <= nonZero_q | (|resNib_d);
`endif
          if (idx_q == LAST_IDX) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            outCarry_q <= carry_d;
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
            outZero_q  <= ~(nonZero_q | (|resNib_d));
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_exec.sv
// Directed bench for nibble_serial_exec: expected results are pushed to a
// scoreboard queue when an op is driven and popped when out_valid appears.
// Zero-flag checks are compiled in with NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN.
module tb_nibble_serial_exec;
  import exec_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        carry;
    logic [4:0]  rd;
    logic        zero;
  } ExpT;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_carry;
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
  logic        out_zero;
`endif

  ExpT sbQ[$];
  ExpT lastExp;
  int  compared   = 0;
  int  mismatched = 0;
  int  cycle      = 0;
  int  acceptCycle = 0;
  int  prevAccept  = 0;

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  nibble_serial_exec #(.NIBBLES(8), .RD_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
    .out_zero   (out_zero),
`endif
    .out_carry  (out_carry)
  );

  // Reference: 33-bit arithmetic, bitwise ops carry nothing, unknown ops add
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 33'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; accept happens on the next posedge
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expRes,
                               input logic expCarry, input bit push);
    ExpT e;
    compare("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    if (push) begin
      e.res   = expRes;
      e.carry = expCarry;
      e.rd    = rd;
      e.zero  = (expRes == 32'd0);
      sbQ.push_back(e);
    end
    @(negedge clk);
    prevAccept  = acceptCycle;
    acceptCycle = cycle;
    in_valid    = 1'b0;
    compare("in_ready_run", {31'd0, in_ready}, 32'd0);
  endtask

  // Waits (bounded) for out_valid, then checks latency and the popped entry
  task automatic checkOutput(input string tag);
    int waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    compare({tag, "_latency"}, cycle - acceptCycle, 32'd8);
    compare({tag, "_sb_size"}, sbQ.size(), 32'd1);
    if (sbQ.size() > 0) begin
      lastExp = sbQ.pop_front();
      compare({tag, "_result"}, out_result, lastExp.res);
      compare({tag, "_carry"}, {31'd0, out_carry}, {31'd0, lastExp.carry});
      compare({tag, "_rd"}, {27'd0, out_rd}, {27'd0, lastExp.rd});
`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
      compare({tag, "_zero"}, {31'd0, out_zero}, {31'd0, lastExp.zero});
`endif
    end
  endtask

  // With out_ready high, the handshake edge passes and the block returns to idle
  task automatic finishHandshake(input string tag);
    @(negedge clk);
    compare({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    compare({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Directed sequence
  initial begin
    logic [32:0] m;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_rd     = 5'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("rst_valid", {31'd0, out_valid}, 32'd0);
    compare("rst_result", out_result, 32'd0);
    compare("rst_rd", {27'd0, out_rd}, 32'd0);
    compare("rst_carry", {31'd0, out_carry}, 32'd0);
    compare("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(EXEC_ADD, 32'hEFFF_FFFF, 32'd1, 5'd3, 32'hF000_0000, 1'b0, 1'b1);
    checkOutput("add_ripple");
    finishHandshake("add_ripple");

    applyStimulus(EXEC_ADD, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd0, 1'b1, 1'b1);
    compare("b2b_spacing", acceptCycle - prevAccept, 32'd10);
    checkOutput("add_wrap");
    finishHandshake("add_wrap");

    applyStimulus(EXEC_SUB, 32'd5, 32'd7, 5'd9, 32'hFFFF_FFFE, 1'b0, 1'b1);
    checkOutput("sub_borrow");
    finishHandshake("sub_borrow");

    applyStimulus(EXEC_SUB, 32'd7, 32'd5, 5'd10, 32'd2, 1'b1, 1'b1);
    checkOutput("sub_noborrow");
    finishHandshake("sub_noborrow");

    applyStimulus(EXEC_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd11, 32'h00F0_1200, 1'b0, 1'b1);
    checkOutput("and");
    finishHandshake("and");

    applyStimulus(EXEC_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd12, 32'hFFF0_FF34, 1'b0, 1'b1);
    checkOutput("or");
    finishHandshake("or");

    applyStimulus(EXEC_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd13, 32'hFF00_ED34, 1'b0, 1'b1);
    checkOutput("xor");
    finishHandshake("xor");

    m = model(3'd6, 32'h8765_4321, 32'h9ABC_DEF0);
    applyStimulus(3'd6, 32'h8765_4321, 32'h9ABC_DEF0, 5'd31, m[31:0], m[32], 1'b1);
    checkOutput("undef_op");
    finishHandshake("undef_op");

    out_ready = 1'b0;
    m = model(3'd1, 32'h0000_1000, 32'h0000_0FFF);
    applyStimulus(EXEC_SUB, 32'h0000_1000, 32'h0000_0FFF, 5'd21, m[31:0], m[32], 1'b1);
    checkOutput("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compare("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      compare("bp_hold_result", out_result, lastExp.res);
      compare("bp_hold_carry", {31'd0, out_carry}, {31'd0, lastExp.carry});
      compare("bp_hold_rd", {27'd0, out_rd}, {27'd0, lastExp.rd});
      compare("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    finishHandshake("bp");

    applyStimulus(EXEC_ADD, 32'h1111_1111, 32'h2222_2222, 5'd4, 32'h3333_3333, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compare("abort_valid", {31'd0, out_valid}, 32'd0);
    compare("abort_result", out_result, 32'd0);
    compare("abort_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(EXEC_ADD, 32'd3, 32'd4, 5'd5, 32'd7, 1'b0, 1'b1);
    checkOutput("post_reset_add");
    finishHandshake("post_reset_add");

`ifdef NIBBLE_SERIAL_EXEC_ZERO_FLAG_EN
    applyStimulus(EXEC_SUB, 32'h1234_5678, 32'h1234_5678, 5'd6, 32'd0, 1'b1, 1'b1);
    checkOutput("zero_sub");
    finishHandshake("zero_sub");

    applyStimulus(EXEC_ADD, 32'd1, 32'd1, 5'd8, 32'd2, 1'b0, 1'b1);
    checkOutput("zero_add");
    finishHandshake("zero_add");
`endif

    compare("sb_drained", sbQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
